// File: rtl/nanorv32_mem_pkg.sv
// nanorv32_mem_pkg: shared widths, abort data and arbiter state encoding
// for the two-master nanorv32 memory port arbiter.
package nanorv32_mem_pkg;

   localparam int MEM_AW = 32;
   localparam int MEM_DW = 32;
   localparam int MEM_SW = 4;

   // Read data returned to a master whose transaction the watchdog aborted.
   localparam logic [MEM_DW-1:0] ABORT_RDATA = 32'h0000_0000;

   // IDLE: no grant outstanding. BUSY: slave port driven by the owner.
   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } arb_state_t;

endpackage

// File: rtl/nanorv32_mem_arbiter.sv
// nanorv32_mem_arbiter: shares one nanorv32 native memory port between the
// CPU (master 0) and a DMA/loader (master 1). One transaction at a time,
// round-robin or fixed-priority grant, optional watchdog abort.
module nanorv32_mem_arbiter
   import nanorv32_mem_pkg::*;
#(
   parameter int PRIO_FIXED = 0,
   parameter int TIMEOUT    = 0
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              m0_valid,
   input  logic              m0_instr,
   input  logic [MEM_AW-1:0] m0_addr,
   input  logic [MEM_DW-1:0] m0_wdata,
   input  logic [MEM_SW-1:0] m0_wstrb,
   output logic              m0_ready,
   output logic [MEM_DW-1:0] m0_rdata,
   input  logic              m1_valid,
   input  logic              m1_instr,
   input  logic [MEM_AW-1:0] m1_addr,
   input  logic [MEM_DW-1:0] m1_wdata,
   input  logic [MEM_SW-1:0] m1_wstrb,
   output logic              m1_ready,
   output logic [MEM_DW-1:0] m1_rdata,
   output logic              s_valid,
   output logic              s_instr,
   output logic [MEM_AW-1:0] s_addr,
   output logic [MEM_DW-1:0] s_wdata,
   output logic [MEM_SW-1:0] s_wstrb,
   input  logic              s_ready,
   input  logic [MEM_DW-1:0] s_rdata,
   output logic              owner,
   output logic              busy,
   output logic              err_timeout
);

   localparam logic        WDOG_EN   = (TIMEOUT != 0);
   localparam logic [15:0] WDOG_LAST = WDOG_EN ? 16'(TIMEOUT - 1) : 16'd0;
   localparam logic        FIXED     = (PRIO_FIXED != 0);

   arb_state_t        r_state;
   arb_state_t        w_nextState;
   logic              r_owner;
   logic              r_lastOwner;
   logic [15:0]       r_wdog;
   logic              w_anyReq;
   logic              w_grantSel;
   logic              w_busy;
   logic              w_timeout;
   logic              w_done;
   logic [MEM_DW-1:0] w_doneRdata;

   // Pick the master to grant from the current requests and the last owner.
   always_comb begin
      w_anyReq   = m0_valid | m1_valid;
      w_grantSel = 1'b0;
      if (m0_valid && m1_valid) begin
         w_grantSel = FIXED ? 1'b0 : ~r_lastOwner;
      end else if (m1_valid) begin
         w_grantSel = 1'b1;
      end
   end

   // Completion happens on slave ready or on a watchdog expiry in BUSY.
   always_comb begin
      w_busy      = (r_state == BUSY);
      w_timeout   = WDOG_EN && w_busy && !s_ready && (r_wdog == WDOG_LAST);
      w_done      = w_busy && (s_ready || w_timeout);
      w_doneRdata = s_ready ? s_rdata : ABORT_RDATA;
   end

   // State register.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   // Next state: IDLE grants any request, BUSY holds until completion.
   always_comb begin
      w_nextState = r_state;
      case (r_state)
         IDLE:    if (w_anyReq) w_nextState = BUSY;
         BUSY:    if (w_done)   w_nextState = IDLE;
         default: w_nextState = IDLE;
      endcase
   end

   // Latch the granted master; last owner starts at 1 so m0 wins the first tie.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_owner     <= 1'b0;
         r_lastOwner <= 1'b1;
      end else if ((r_state == IDLE) && w_anyReq) begin
         r_owner     <= w_grantSel;
         r_lastOwner <= w_grantSel;
      end
   end

   // Watchdog counts BUSY cycles and restarts from zero on each grant.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_wdog <= 16'd0;
      end else if (r_state == IDLE) begin
         r_wdog <= 16'd0;
      end else begin
         r_wdog <= r_wdog + 16'd1;
      end
   end

   // Route the owner's payload to the slave and the completion back to the owner.
   always_comb begin
      s_valid  = w_busy;
      s_instr  = 1'b0;
      s_addr   = '0;
      s_wdata  = '0;
      s_wstrb  = '0;
      m0_ready = 1'b0;
      m1_ready = 1'b0;
      m0_rdata = '0;
      m1_rdata = '0;
      if (w_busy) begin
         if (r_owner == 1'b0) begin
            s_instr  = m0_instr;
            s_addr   = m0_addr;
            s_wdata  = m0_wdata;
            s_wstrb  = m0_wstrb;
            m0_ready = w_done;
            m0_rdata = w_done ? w_doneRdata : '0;
         end else begin
            s_instr  = m1_instr;
            s_addr   = m1_addr;
            s_wdata  = m1_wdata;
            s_wstrb  = m1_wstrb;
            m1_ready = w_done;
            m1_rdata = w_done ? w_doneRdata : '0;
         end
      end
   end

   // Status outputs.
   always_comb begin
      owner       = r_owner;
      busy        = w_busy;
      err_timeout = w_timeout;
   end

endmodule

// File: tb/tb_nanorv32_mem_arbiter.sv
// tb_nanorv32_mem_arbiter: two arbiter instances (round-robin with an
// 8-cycle watchdog, and fixed priority without watchdog) driven by directed
// scenarios and then random masters/slaves, compared against a
// transaction-level model every cycle.
module tb_nanorv32_mem_arbiter;

   localparam int TMO0 = 8;
   localparam int FIX0 = 0;
   localparam int TMO1 = 0;
   localparam int FIX1 = 1;

   logic        clk;
   logic        resetn     [2];
   logic        m0Valid    [2];
   logic        m1Valid    [2];
   logic        m0Instr    [2];
   logic        m1Instr    [2];
   logic [31:0] m0Addr     [2];
   logic [31:0] m1Addr     [2];
   logic [31:0] m0Wdata    [2];
   logic [31:0] m1Wdata    [2];
   logic [3:0]  m0Wstrb    [2];
   logic [3:0]  m1Wstrb    [2];
   logic        m0Ready    [2];
   logic        m1Ready    [2];
   logic [31:0] m0Rdata    [2];
   logic [31:0] m1Rdata    [2];
   logic        sValid     [2];
   logic        sInstr     [2];
   logic [31:0] sAddr      [2];
   logic [31:0] sWdata     [2];
   logic [3:0]  sWstrb     [2];
   logic        sReady     [2];
   logic [31:0] sRdata     [2];
   logic        owner      [2];
   logic        busy       [2];
   logic        errTimeout [2];

   int checks = 0;
   int passes = 0;

   // Model: is a transaction in flight, who owns it, who was granted last,
   // and how many BUSY cycles have already elapsed.
   bit mBusy  [2];
   bit mOwner [2];
   bit mLast  [2];
   int mAge   [2];

   int          tmoK;
   bit          fixK;
   bit          eValid, eInstr, eR0, eR1, eTmo, eDone;
   logic [31:0] eAddr, eWdata, eRd0, eRd1;
   logic [3:0]  eWstrb;

   logic rs0 [2];
   logic rs1 [2];

   nanorv32_mem_arbiter #(.PRIO_FIXED(FIX0), .TIMEOUT(TMO0)) dutRr (
      .clk(clk), .resetn(resetn[0]),
      .m0_valid(m0Valid[0]), .m0_instr(m0Instr[0]), .m0_addr(m0Addr[0]),
      .m0_wdata(m0Wdata[0]), .m0_wstrb(m0Wstrb[0]), .m0_ready(m0Ready[0]), .m0_rdata(m0Rdata[0]),
      .m1_valid(m1Valid[0]), .m1_instr(m1Instr[0]), .m1_addr(m1Addr[0]),
      .m1_wdata(m1Wdata[0]), .m1_wstrb(m1Wstrb[0]), .m1_ready(m1Ready[0]), .m1_rdata(m1Rdata[0]),
      .s_valid(sValid[0]), .s_instr(sInstr[0]), .s_addr(sAddr[0]), .s_wdata(sWdata[0]),
      .s_wstrb(sWstrb[0]), .s_ready(sReady[0]), .s_rdata(sRdata[0]),
      .owner(owner[0]), .busy(busy[0]), .err_timeout(errTimeout[0])
   );

   nanorv32_mem_arbiter #(.PRIO_FIXED(FIX1), .TIMEOUT(TMO1)) dutFx (
      .clk(clk), .resetn(resetn[1]),
      .m0_valid(m0Valid[1]), .m0_instr(m0Instr[1]), .m0_addr(m0Addr[1]),
      .m0_wdata(m0Wdata[1]), .m0_wstrb(m0Wstrb[1]), .m0_ready(m0Ready[1]), .m0_rdata(m0Rdata[1]),
      .m1_valid(m1Valid[1]), .m1_instr(m1Instr[1]), .m1_addr(m1Addr[1]),
      .m1_wdata(m1Wdata[1]), .m1_wstrb(m1Wstrb[1]), .m1_ready(m1Ready[1]), .m1_rdata(m1Rdata[1]),
      .s_valid(sValid[1]), .s_instr(sInstr[1]), .s_addr(sAddr[1]), .s_wdata(sWdata[1]),
      .s_wstrb(sWstrb[1]), .s_ready(sReady[1]), .s_rdata(sRdata[1]),
      .owner(owner[1]), .busy(busy[1]), .err_timeout(errTimeout[1])
   );

   // 10-unit clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // One comparison; every check in the bench funnels through here.
   task automatic checkOutput(input string name, input int k,
                              input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected)
         $display("[TB] FAIL %s[%0d] @%0t: got 0x%h, want 0x%h", name, k, $time, actual, expected);
      else
         passes++;
   endtask

   task automatic checkBit(input string name, input int k, input logic actual, input logic expected);
      checkOutput(name, k, {31'b0, actual}, {31'b0, expected});
   endtask

   // Raise a request on master m of instance k.
   task automatic applyStimulus(input int k, input int m, input logic instr,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [3:0] wstrb);
      if (m == 0) begin
         m0Valid[k] = 1'b1; m0Instr[k] = instr; m0Addr[k] = addr;
         m0Wdata[k] = wdata; m0Wstrb[k] = wstrb;
      end else begin
         m1Valid[k] = 1'b1; m1Instr[k] = instr; m1Addr[k] = addr;
         m1Wdata[k] = wdata; m1Wstrb[k] = wstrb;
      end
   endtask

   task automatic dropRequest(input int k, input int m);
      if (m == 0) m0Valid[k] = 1'b0;
      else        m1Valid[k] = 1'b0;
   endtask

   // Wait (bounded) for the slave request, check the forwarded payload,
   // answer with rd one cycle later and check it reaches the right master.
   task automatic serveTransaction(input int k, input logic expOwner, input logic [31:0] expAddr,
                                   input logic [31:0] expWdata, input logic [3:0] expWstrb,
                                   input logic [31:0] rd, input bit dropAfter);
      int waited = 0;
      @(negedge clk);
      while (!sValid[k] && waited < 20) begin
         @(negedge clk);
         waited++;
      end
      checkBit("grant s_valid", k, sValid[k], 1'b1);
      checkBit("grant owner", k, owner[k], expOwner);
      checkOutput("s_addr", k, sAddr[k], expAddr);
      checkOutput("s_wdata", k, sWdata[k], expWdata);
      checkOutput("s_wstrb", k, {28'b0, sWstrb[k]}, {28'b0, expWstrb});
      @(posedge clk); #1;
      sReady[k] = 1'b1;
      sRdata[k] = rd;
      @(negedge clk);
      checkBit("owner ready", k, expOwner ? m1Ready[k] : m0Ready[k], 1'b1);
      checkOutput("owner rdata", k, expOwner ? m1Rdata[k] : m0Rdata[k], rd);
      checkBit("other ready", k, expOwner ? m0Ready[k] : m1Ready[k], 1'b0);
      @(posedge clk); #1;
      sReady[k] = 1'b0;
      if (dropAfter) dropRequest(k, int'(expOwner));
   endtask

   // Every falling edge: derive the expected outputs of both instances from
   // the transaction-level model, compare them, then advance the model.
   always @(negedge clk) begin
      for (int k = 0; k < 2; k++) begin
         tmoK = (k == 0) ? TMO0 : TMO1;
         fixK = (k == 0) ? (FIX0 != 0) : (FIX1 != 0);
         if (!resetn[k]) begin
            mBusy[k] = 1'b0; mOwner[k] = 1'b0; mLast[k] = 1'b1; mAge[k] = 0;
         end
         eValid = 0; eInstr = 0; eAddr = '0; eWdata = '0; eWstrb = '0;
         eR0 = 0; eR1 = 0; eRd0 = '0; eRd1 = '0; eTmo = 0; eDone = 0;
         if (mBusy[k]) begin
            eValid = 1'b1;
            eInstr = mOwner[k] ? m1Instr[k] : m0Instr[k];
            eAddr  = mOwner[k] ? m1Addr[k]  : m0Addr[k];
            eWdata = mOwner[k] ? m1Wdata[k] : m0Wdata[k];
            eWstrb = mOwner[k] ? m1Wstrb[k] : m0Wstrb[k];
            eTmo   = (tmoK != 0) && !sReady[k] && (mAge[k] + 1 == tmoK);
            eDone  = sReady[k] || eTmo;
            if (eDone) begin
               if (mOwner[k]) begin eR1 = 1'b1; eRd1 = sReady[k] ? sRdata[k] : 32'h0; end
               else           begin eR0 = 1'b1; eRd0 = sReady[k] ? sRdata[k] : 32'h0; end
            end
         end
         checkBit("m s_valid", k, sValid[k], eValid);
         checkBit("m s_instr", k, sInstr[k], eInstr);
         checkOutput("m s_addr", k, sAddr[k], eAddr);
         checkOutput("m s_wdata", k, sWdata[k], eWdata);
         checkOutput("m s_wstrb", k, {28'b0, sWstrb[k]}, {28'b0, eWstrb});
         checkBit("m m0_ready", k, m0Ready[k], eR0);
         checkBit("m m1_ready", k, m1Ready[k], eR1);
         checkOutput("m m0_rdata", k, m0Rdata[k], eRd0);
         checkOutput("m m1_rdata", k, m1Rdata[k], eRd1);
         checkBit("m owner", k, owner[k], mOwner[k]);
         checkBit("m busy", k, busy[k], mBusy[k]);
         checkBit("m err_timeout", k, errTimeout[k], eTmo);
         if (resetn[k]) begin
            if (mBusy[k]) begin
               if (eDone) mBusy[k] = 1'b0;
               else       mAge[k]++;
            end else if (m0Valid[k] || m1Valid[k]) begin
               if (m0Valid[k] && m1Valid[k]) mOwner[k] = fixK ? 1'b0 : !mLast[k];
               else                          mOwner[k] = m1Valid[k];
               mLast[k] = mOwner[k];
               mBusy[k] = 1'b1;
               mAge[k]  = 0;
            end
         end
      end
   end

   // Directed scenarios first, then random traffic on both instances.
   initial begin
      int busyCount;
      bit seen;
      for (int k = 0; k < 2; k++) begin
         resetn[k] = 1'b0;
         m0Valid[k] = 0; m0Instr[k] = 0; m0Addr[k] = '0; m0Wdata[k] = '0; m0Wstrb[k] = '0;
         m1Valid[k] = 0; m1Instr[k] = 0; m1Addr[k] = '0; m1Wdata[k] = '0; m1Wstrb[k] = '0;
         sReady[k] = 0; sRdata[k] = '0;
      end
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
         checkBit("reset s_valid", k, sValid[k], 1'b0);
         checkBit("reset owner", k, owner[k], 1'b0);
         checkBit("reset busy", k, busy[k], 1'b0);
         checkOutput("reset m0_rdata", k, m0Rdata[k], 32'h0);
      end
      @(posedge clk); #1;
      resetn[0] = 1'b1;
      resetn[1] = 1'b1;
      @(posedge clk); #1;

      // m0 read of 0x100 with a one-cycle slave.
      applyStimulus(0, 0, 1'b0, 32'h0000_0100, 32'h0, 4'h0);
      @(negedge clk);
      checkBit("t0 s_valid", 0, sValid[0], 1'b0);
      @(posedge clk); #1;
      @(negedge clk);
      checkBit("t1 s_valid", 0, sValid[0], 1'b1);
      checkOutput("t1 s_addr", 0, sAddr[0], 32'h0000_0100);
      checkBit("t1 m0_ready", 0, m0Ready[0], 1'b0);
      checkBit("t1 m1_ready", 0, m1Ready[0], 1'b0);
      @(posedge clk); #1;
      sReady[0] = 1'b1;
      sRdata[0] = 32'h1234_5678;
      @(negedge clk);
      checkBit("t2 m0_ready", 0, m0Ready[0], 1'b1);
      checkOutput("t2 m0_rdata", 0, m0Rdata[0], 32'h1234_5678);
      checkBit("t2 m1_ready", 0, m1Ready[0], 1'b0);
      @(posedge clk); #1;
      sReady[0] = 1'b0;
      dropRequest(0, 0);
      @(negedge clk);
      checkBit("t3 s_valid", 0, sValid[0], 1'b0);
      checkBit("t3 busy", 0, busy[0], 1'b0);

      // Simultaneous requests right after reset, round-robin: m0 then m1.
      @(posedge clk); #1;
      resetn[0] = 1'b0;
      @(posedge clk); #1;
      resetn[0] = 1'b1;
      applyStimulus(0, 0, 1'b0, 32'h0000_0300, 32'h0, 4'h0);
      applyStimulus(0, 1, 1'b0, 32'h0000_0200, 32'hDEAD_BEEF, 4'hF);
      serveTransaction(0, 1'b0, 32'h0000_0300, 32'h0, 4'h0, 32'hA5A5_5A5A, 1'b1);
      serveTransaction(0, 1'b1, 32'h0000_0200, 32'hDEAD_BEEF, 4'hF, 32'h0, 1'b1);

      // Watchdog: slave never answers, abort in the eighth BUSY cycle.
      applyStimulus(0, 0, 1'b1, 32'h0000_0400, 32'h0, 4'h0);
      busyCount = 0;
      seen = 0;
      for (int c = 0; c < 20 && !seen; c++) begin
         @(negedge clk);
         if (busy[0]) busyCount++;
         if (m0Ready[0]) begin
            seen = 1;
            checkOutput("abort rdata", 0, m0Rdata[0], 32'h0);
            checkBit("abort err_timeout", 0, errTimeout[0], 1'b1);
         end
      end
      checkBit("abort seen", 0, seen, 1'b1);
      checkOutput("abort busy cycles", 0, busyCount, 32'd8);
      @(posedge clk); #1;
      dropRequest(0, 0);
      @(negedge clk);
      checkBit("after abort busy", 0, busy[0], 1'b0);
      checkBit("after abort err", 0, errTimeout[0], 1'b0);

      // Asynchronous reset one cycle after an m1 grant, then a fresh m1 request.
      @(posedge clk); #1;
      applyStimulus(0, 1, 1'b0, 32'h0000_0500, 32'h0, 4'h0);
      @(negedge clk);
      @(posedge clk); #1;
      @(negedge clk);
      checkBit("pre-reset busy", 0, busy[0], 1'b1);
      checkBit("pre-reset owner", 0, owner[0], 1'b1);
      #2;
      resetn[0] = 1'b0;
      #1;
      checkBit("async s_valid", 0, sValid[0], 1'b0);
      checkBit("async busy", 0, busy[0], 1'b0);
      checkBit("async owner", 0, owner[0], 1'b0);
      dropRequest(0, 1);
      @(negedge clk);
      @(posedge clk); #1;
      resetn[0] = 1'b1;
      applyStimulus(0, 1, 1'b0, 32'h0000_0600, 32'h0000_CAFE, 4'h3);
      serveTransaction(0, 1'b1, 32'h0000_0600, 32'h0000_CAFE, 4'h3, 32'h0BAD_F00D, 1'b1);

      // Fixed priority: m0 back-to-back three times starves a constant m1.
      applyStimulus(1, 1, 1'b0, 32'h0000_2000, 32'h0, 4'h0);
      applyStimulus(1, 0, 1'b1, 32'h0000_3000, 32'h0, 4'h0);
      serveTransaction(1, 1'b0, 32'h0000_3000, 32'h0, 4'h0, 32'h1111_0000, 1'b0);
      m0Addr[1] = 32'h0000_3004;
      serveTransaction(1, 1'b0, 32'h0000_3004, 32'h0, 4'h0, 32'h2222_0000, 1'b0);
      m0Addr[1] = 32'h0000_3008;
      serveTransaction(1, 1'b0, 32'h0000_3008, 32'h0, 4'h0, 32'h3333_0000, 1'b1);
      serveTransaction(1, 1'b1, 32'h0000_2000, 32'h0, 4'h0, 32'h4444_0000, 1'b1);

      // m1 byte write to the MMIO space, forwarded unchanged.
      applyStimulus(1, 1, 1'b0, 32'h1000_0000, 32'h0000_0041, 4'b0001);
      serveTransaction(1, 1'b1, 32'h1000_0000, 32'h0000_0041, 4'b0001, 32'h0, 1'b1);

      // Random masters that hold valid until ready, random slave, rare resets.
      for (int n = 0; n < 3000; n++) begin
         @(negedge clk);
         for (int k = 0; k < 2; k++) begin
            rs0[k] = m0Ready[k];
            rs1[k] = m1Ready[k];
         end
         @(posedge clk); #1;
         for (int k = 0; k < 2; k++) begin
            resetn[k] = ($urandom_range(0, 299) != 0);
            if (!m0Valid[k] || rs0[k]) begin
               m0Valid[k] = ($urandom_range(0, 2) != 0);
               m0Instr[k] = 1'($urandom);
               m0Addr[k]  = $urandom;
               m0Wdata[k] = $urandom;
               m0Wstrb[k] = ($urandom_range(0, 1) != 0) ? 4'($urandom) : 4'h0;
            end
            if (!m1Valid[k] || rs1[k]) begin
               m1Valid[k] = ($urandom_range(0, 2) != 0);
               m1Instr[k] = 1'($urandom);
               m1Addr[k]  = $urandom;
               m1Wdata[k] = $urandom;
               m1Wstrb[k] = ($urandom_range(0, 1) != 0) ? 4'($urandom) : 4'h0;
            end
            sReady[k] = ($urandom_range(0, 9) < 3);
            sRdata[k] = $urandom;
         end
      end
      @(negedge clk);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule

// File: doc/nanorv32_mem_arbiter.md
# nanorv32_mem_arbiter

Two-master arbiter that shares the single nanorv32 native memory port (valid/ready, `mem_*` signalling) between master 0 (the CPU core) and master 1 (a DMA engine or debug/firmware loader). It sits between the masters and the memory/MMIO slave. One transaction is granted at a time. Grant order is round-robin or fixed-priority. An optional watchdog aborts transactions the slave never answers.

## Interface
Parameters:
- `PRIO_FIXED`, default 0. 0 = round-robin; 1 = master 0 always wins ties.
- `TIMEOUT`, default 0. Cycles in BUSY before abort; 0 disables the watchdog. Legal range 0..65535.

Ports:
- Clocking: one clock; reset is asynchronous and active-low (`clk`, `resetn`).
- `clk`  in  1  clock
- `resetn`  in  1  asynchronous active-low reset
- `m0_valid`, `m1_valid`  in  1  request from the master; held until that master's ready
- `m0_instr`, `m1_instr`  in  1  instruction-fetch flag
- `m0_addr`, `m1_addr`  in  32  byte address
- `m0_wdata`, `m1_wdata`  in  32  write data
- `m0_wstrb`, `m1_wstrb`  in  4  byte strobes; 0 = read
- `m0_ready`, `m1_ready`  out  1  completion pulse to the master
- `m0_rdata`, `m1_rdata`  out  32  read data, valid while the matching ready is high
- `s_valid`  out  1  request to the slave
- `s_instr`  out  1  forwarded instr flag
- `s_addr`  out  32  forwarded address
- `s_wdata`  out  32  forwarded write data
- `s_wstrb`  out  4  forwarded strobes
- `s_ready`  in  1  slave completion
- `s_rdata`  in  32  slave read data
- `owner`  out  1  current/last granted master
- `busy`  out  1  a transaction is in flight
- `err_timeout`  out  1  one-cycle pulse when the watchdog aborts

## Operation
- States:
  - IDLE: no grant.
  - BUSY: slave port driven by `owner`.
- IDLE transitions:
  - No request: stay in IDLE.
  - One requester: grant it.
  - Both requesting, `PRIO_FIXED`=0: grant the master other than `last_owner`.
  - Both requesting, `PRIO_FIXED`=1: grant m0.
  - On grant, latch `owner`, set `last_owner` = `owner`, go to BUSY.
- BUSY:
  - `s_valid`=1.
  - `s_instr/addr/wdata/wstrb` are muxed from `owner`'s inputs.
  - The other master's ready stays 0.
- BUSY completion (`s_ready`=1):
  - `m<owner>_ready` = 1 combinationally in that cycle.
  - `m<owner>_rdata` = `s_rdata`.
  - Next state is IDLE.
- Watchdog:
  - `wdog` counts BUSY cycles, cleared on entry to BUSY.
  - When `TIMEOUT`≠0 and `wdog`==`TIMEOUT`-1 with no `s_ready`: pulse `m<owner>_ready` with rdata 0x0000_0000, pulse `err_timeout`, go to IDLE.
  - The counter is 16 bits; it does not wrap while BUSY because `TIMEOUT`≤65535.
- `s_ready` while IDLE is ignored; no master sees it.
- Owner drops valid while BUSY (protocol violation): the grant is held until `s_ready` or timeout. `s_valid` depends only on state.
- Non-owner rdata outputs are 0. `s_*` payload outputs are 0 in IDLE.

## Timing
- Reset values: state IDLE, `s_valid`=0, `s_*` payload 0, `m*_ready`=0, `m*_rdata`=0, `owner`=0, `last_owner`=1 (so m0 wins the first tie), `busy`=0, `err_timeout`=0, `wdog`=0.
- Reset asserted mid-transaction: outputs clear immediately (asynchronous). The slave transaction is abandoned.
- Grant latency is 1 cycle: a request seen in IDLE in cycle t gives `s_valid` in cycle t+1.
- With a 1-cycle slave, `s_ready` arrives in t+2 and `m_ready` is in t+2, combinational from `s_ready`.
- The cycle after `s_ready` is always IDLE with `s_valid`=0. The slave therefore never sees valid with its own ready still high.
- Peak throughput with a 1-cycle slave: one transaction per 3 cycles.
- `err_timeout` coincides with the aborted `m_ready` pulse.

## Structure
- Shared package `nanorv32_mem_pkg`:
  - state enum (IDLE, BUSY);
  - `MEM_AW`=32, `MEM_DW`=32, `MEM_SW`=4;
  - `ABORT_RDATA`=32'h0.
- No sub-module. Grant selection, payload mux and watchdog stay inline.

## Test plan
- m0 reads 0x0000_0100; the slave answers 0x1234_5678 one cycle after `s_valid`. Required: `s_addr`=0x100 in t+1; `m0_ready`=1 and `m0_rdata`=0x1234_5678 in t+2; `m1_ready`=0 throughout.
- m0 read and m1 write (0x200, 0xDEAD_BEEF, wstrb 1111) asserted together after reset, `PRIO_FIXED`=0. Required: m0 served first, then m1; the slave sees 0xDEAD_BEEF/1111 in the second transaction.
- `PRIO_FIXED`=1 with m0 requesting back-to-back for 3 transactions and m1 requesting constantly. Required: `owner`=0 for all 3; m1 is granted only after m0 deasserts.
- `TIMEOUT`=8, slave never readies. Required: BUSY for 8 cycles; then `m_ready`=1, rdata 0 and `err_timeout`=1 for one cycle; IDLE next cycle.
- `resetn` pulled low in the cycle after a grant. Required: `s_valid` and `busy` drop without a clock edge; `owner`=0; after release, a fresh m1 request is granted normally.
- m1 writes 0x41 to 0x1000_0000 with wstrb 0001. Required: `s_addr`=0x1000_0000, `s_wdata`=0x41, `s_wstrb`=0001 forwarded unchanged.
